encoder_8to3_pending: RTL and testbench

- Registered 8-to-3 priority encoder. It is the inverse of the existing 3-to-8 decoder.
- Eight one-hot request lines are latched into a pending register. The block presents the winning index as a 3-bit code under a valid/ack handshake and clears the served bit on acknowledge.
- Sits between request sources (interrupt-style lines) and a consumer that services one index at a time.

---
 rtl/encoder_8to3_pending_if.sv | 21 ++
 rtl/encoder_8to3_pending.sv | 87 ++++++++
 tb/tb_encoder_8to3_pending.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_8to3_pending_if.sv
// Request/offer bus between interrupt-style sources, the 8-to-3 pending encoder and its consumer.
// The master side drives requests and acknowledges; the slave side (the encoder) presents codes.
interface encoder_8to3_pending_if;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pending;
    logic       lost;

    modport master (
        output en, req, ack,
        input  valid, code, pending, lost
    );

    modport slave (
        input  en, req, ack,
        output valid, code, pending, lost
    );
endinterface

// File: rtl/encoder_8to3_pending.sv
// Registered 8-to-3 priority encoder: latches request lines into a pending register and
// offers one winning index at a time under a valid/ack handshake, clearing it on acknowledge.
module encoder_8to3_pending #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    encoder_8to3_pending_if.slave bus
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t     state, state_n;
    logic [7:0] pending_q, pending_n;
    logic [2:0] code_q, code_n;
    logic       valid_q, valid_n;
    logic       lost_q, lost_n;
    logic [7:0] cap;
    logic [7:0] clr;
    logic [2:0] win;

    // Later loop iterations override earlier ones, so the last set bit visited wins.
    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (HIGH_FIRST) begin
                if (pending_q[i]) win = i[2:0];
            end else begin
                if (pending_q[7 - i]) win = 3'(7 - i);
            end
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code_q;
        valid_n = valid_q;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (pending_q != '0) begin
                    state_n = OFFER;
                    code_n  = win;
                    valid_n = 1'b1;
                end
            end
            OFFER: begin
                if (bus.ack) begin
                    clr[code_q] = 1'b1;
                    valid_n     = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        cap       = bus.en ? bus.req : '0;
        // A new request on the bit being served keeps it set and is not a loss.
        pending_n = (pending_q & ~clr) | cap;
        lost_n    = lost_q | (|(cap & pending_q & ~clr));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state     <= state_n;
            pending_q <= pending_n;
            code_q    <= code_n;
            valid_q   <= valid_n;
            lost_q    <= lost_n;
        end
    end

    assign bus.valid   = valid_q;
    assign bus.code    = code_q;
    assign bus.pending = pending_q;
    assign bus.lost    = lost_q;

endmodule

// File: tb/tb_encoder_8to3_pending.sv
// Bench for encoder_8to3_pending: both priority orders side by side, directed scenarios
// with fixed expectations plus a randomized run against a behavioural reference.
module tb_encoder_8to3_pending;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ack;
    logic [7:0] req;

    always #5 clk = ~clk;

    encoder_8to3_pending_if hi_if ();
    encoder_8to3_pending_if lo_if ();

    assign hi_if.en  = en;
    assign hi_if.req = req;
    assign hi_if.ack = ack;
    assign lo_if.en  = en;
    assign lo_if.req = req;
    assign lo_if.ack = ack;

    encoder_8to3_pending #(.HIGH_FIRST(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(hi_if));
    encoder_8to3_pending #(.HIGH_FIRST(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(lo_if));

    // Reference state, index 1 = HIGH_FIRST=1, index 0 = HIGH_FIRST=0.
    logic [7:0] m_pend  [2];
    logic       m_valid [2];
    logic [2:0] m_code  [2];
    logic       m_lost  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Highest set bit (floor log2) or lowest set bit (isolate with p & -p, then log2).
    function automatic logic [2:0] pick(input bit high_first, input logic [7:0] p);
        int unsigned v;
        int unsigned n;
        v = p;
        n = 0;
        if (!high_first) v = v & (32'd0 - v);
        while (v > 1) begin
            v = v >> 1;
            n++;
        end
        return n[2:0];
    endfunction

    task automatic step(input logic r, input logic e, input logic a, input logic [7:0] q);
        rst = r;
        en  = e;
        ack = a;
        req = q;
        @(posedge clk);
        for (int h = 0; h < 2; h++) begin
            logic [7:0] cap;
            logic [7:0] served;
            if (r) begin
                m_pend[h]  = 8'h00;
                m_valid[h] = 1'b0;
                m_code[h]  = 3'd0;
                m_lost[h]  = 1'b0;
            end else begin
                cap    = e ? q : 8'h00;
                served = (m_valid[h] && a) ? 8'(1 << m_code[h]) : 8'h00;
                if ((cap & m_pend[h] & ~served) != 8'h00) m_lost[h] = 1'b1;
                if (m_valid[h]) begin
                    if (a) m_valid[h] = 1'b0;
                end else if (m_pend[h] != 8'h00) begin
                    m_code[h]  = pick(h == 1, m_pend[h]);
                    m_valid[h] = 1'b1;
                end
                m_pend[h] = (m_pend[h] & ~served) | cap;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        n_checks++;
        if ({hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_hi: got v=%b c=%b p=%h l=%b, expected all zero",
                     hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost);
        end
        n_checks++;
        if ({lo_if.valid, lo_if.code, lo_if.pending, lo_if.lost} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_lo: got v=%b c=%b p=%h l=%b, expected all zero",
                     lo_if.valid, lo_if.code, lo_if.pending, lo_if.lost);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            n_checks++;
            if (hi_if.valid !== 1'b0 || lo_if.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid cycle %0d: got hi=%b lo=%b, expected 0", i, hi_if.valid, lo_if.valid);
            end
        end
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, 1'b0, 8'h04);
        n_checks++;
        if ({hi_if.pending, hi_if.valid} !== {8'h04, 1'b0}) begin
            n_fail++;
            $display("FAIL single_capture: got p=%h v=%b, expected p=04 v=0", hi_if.pending, hi_if.valid);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({hi_if.valid, hi_if.code} !== 4'b1_010) begin
            n_fail++;
            $display("FAIL single_offer: got v=%b c=%b, expected v=1 c=010", hi_if.valid, hi_if.code);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({hi_if.valid, hi_if.code, hi_if.pending} !== {4'b1_010, 8'h04}) begin
            n_fail++;
            $display("FAIL single_hold: got v=%b c=%b p=%h, expected v=1 c=010 p=04",
                     hi_if.valid, hi_if.code, hi_if.pending);
        end
        step(1'b0, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if ({hi_if.valid, hi_if.pending} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL single_ack: got v=%b p=%h, expected v=0 p=00", hi_if.valid, hi_if.pending);
        end
    endtask

    task automatic test_priority();
        logic [2:0] hi_exp [2];
        logic [2:0] lo_exp [2];
        logic [7:0] hi_rem [2];
        logic [7:0] lo_rem [2];
        hi_exp = '{3'd7, 3'd0};
        lo_exp = '{3'd0, 3'd7};
        hi_rem = '{8'h01, 8'h00};
        lo_rem = '{8'h80, 8'h00};
        step(1'b0, 1'b1, 1'b1, 8'h81);
        n_checks++;
        if ({hi_if.pending, hi_if.valid, lo_if.pending, lo_if.valid} !== {8'h81, 1'b0, 8'h81, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_capture: got hi p=%h v=%b lo p=%h v=%b, expected p=81 v=0 for both",
                     hi_if.pending, hi_if.valid, lo_if.pending, lo_if.valid);
        end
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'b1, 1'b1, 8'h00);
            n_checks++;
            if ({hi_if.valid, hi_if.code, lo_if.valid, lo_if.code} !== {1'b1, hi_exp[r], 1'b1, lo_exp[r]}) begin
                n_fail++;
                $display("FAIL prio_offer round %0d: got hi v=%b c=%b lo v=%b c=%b, expected hi c=%b lo c=%b",
                         r, hi_if.valid, hi_if.code, lo_if.valid, lo_if.code, hi_exp[r], lo_exp[r]);
            end
            step(1'b0, 1'b1, 1'b1, 8'h00);
            n_checks++;
            if ({hi_if.valid, hi_if.pending, lo_if.valid, lo_if.pending} !== {1'b0, hi_rem[r], 1'b0, lo_rem[r]}) begin
                n_fail++;
                $display("FAIL prio_ack round %0d: got hi v=%b p=%h lo v=%b p=%h, expected hi p=%h lo p=%h",
                         r, hi_if.valid, hi_if.pending, lo_if.valid, lo_if.pending, hi_rem[r], lo_rem[r]);
            end
        end
    endtask

    task automatic test_preempt_lost();
        step(1'b0, 1'b1, 1'b0, 8'h08);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h80);
        n_checks++;
        if ({hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost} !== {4'b1_011, 8'h88, 1'b0}) begin
            n_fail++;
            $display("FAIL no_preempt: got v=%b c=%b p=%h l=%b, expected v=1 c=011 p=88 l=0",
                     hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({hi_if.valid, hi_if.code, lo_if.valid, lo_if.code} !== {4'b1_111, 4'b1_111}) begin
            n_fail++;
            $display("FAIL next_offer: got hi v=%b c=%b lo v=%b c=%b, expected v=1 c=111",
                     hi_if.valid, hi_if.code, lo_if.valid, lo_if.code);
        end
        step(1'b0, 1'b1, 1'b0, 8'h80);
        n_checks++;
        if ({hi_if.lost, lo_if.lost, hi_if.pending} !== {2'b11, 8'h80}) begin
            n_fail++;
            $display("FAIL lost_set: got hi l=%b lo l=%b p=%h, expected l=1 p=80",
                     hi_if.lost, lo_if.lost, hi_if.pending);
        end
        step(1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            n_checks++;
            if ({hi_if.lost, hi_if.valid, hi_if.pending} !== {2'b10, 8'h00}) begin
                n_fail++;
                $display("FAIL lost_sticky cycle %0d: got l=%b v=%b p=%h, expected l=1 v=0 p=00",
                         i, hi_if.lost, hi_if.valid, hi_if.pending);
            end
        end
    endtask

    task automatic test_set_wins_enable();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (hi_if.lost !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_cleared: got l=%b, expected 0", hi_if.lost);
        end
        step(1'b0, 1'b1, 1'b0, 8'h20);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h20);
        n_checks++;
        if ({hi_if.valid, hi_if.pending, hi_if.lost} !== {1'b0, 8'h20, 1'b0}) begin
            n_fail++;
            $display("FAIL set_wins: got v=%b p=%h l=%b, expected v=0 p=20 l=0",
                     hi_if.valid, hi_if.pending, hi_if.lost);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({hi_if.valid, hi_if.code} !== 4'b1_101) begin
            n_fail++;
            $display("FAIL reoffer: got v=%b c=%b, expected v=1 c=101", hi_if.valid, hi_if.code);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h02);
            n_checks++;
            if ({hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost} !== {4'b1_101, 8'h20, 1'b0}) begin
                n_fail++;
                $display("FAIL en_low cycle %0d: got v=%b c=%b p=%h l=%b, expected v=1 c=101 p=20 l=0",
                         i, hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost);
            end
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if ({hi_if.valid, hi_if.pending} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL ack_en_low: got v=%b p=%h, expected v=0 p=00", hi_if.valid, hi_if.pending);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b0, 8'hF0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({hi_if.valid, hi_if.code, hi_if.pending, lo_if.code} !== {4'b1_111, 8'hF0, 3'b100}) begin
            n_fail++;
            $display("FAIL mid_setup: got v=%b c=%b p=%h lo c=%b, expected v=1 c=111 p=f0 lo c=100",
                     hi_if.valid, hi_if.code, hi_if.pending, lo_if.code);
        end
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        n_checks++;
        if ({hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost,
             lo_if.valid, lo_if.code, lo_if.pending, lo_if.lost} !== 26'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got hi v=%b c=%b p=%h l=%b lo v=%b c=%b p=%h l=%b, expected all zero",
                     hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost,
                     lo_if.valid, lo_if.code, lo_if.pending, lo_if.lost);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'h00);
            n_checks++;
            if (hi_if.valid !== 1'b0 || lo_if.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle cycle %0d: got hi v=%b lo v=%b, expected 0",
                         i, hi_if.valid, lo_if.valid);
            end
        end
    endtask

    task automatic test_random();
        logic       r, e, a;
        logic [7:0] q;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 2) != 0);
            q = 8'($urandom & $urandom & $urandom);
            step(r, e, a, q);
            n_checks++;
            if ({hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost} !==
                {m_valid[1], m_code[1], m_pend[1], m_lost[1]}) begin
                n_fail++;
                $display("FAIL random_hi cycle %0d: got v=%b c=%b p=%h l=%b, expected v=%b c=%b p=%h l=%b",
                         i, hi_if.valid, hi_if.code, hi_if.pending, hi_if.lost,
                         m_valid[1], m_code[1], m_pend[1], m_lost[1]);
            end
            n_checks++;
            if ({lo_if.valid, lo_if.code, lo_if.pending, lo_if.lost} !==
                {m_valid[0], m_code[0], m_pend[0], m_lost[0]}) begin
                n_fail++;
                $display("FAIL random_lo cycle %0d: got v=%b c=%b p=%h l=%b, expected v=%b c=%b p=%h l=%b",
                         i, lo_if.valid, lo_if.code, lo_if.pending, lo_if.lost,
                         m_valid[0], m_code[0], m_pend[0], m_lost[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        ack = 1'b0;
        req = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_preempt_lost();
        test_set_wins_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
